circle_anim_ctrl: RTL and testbench
===================================

CIRCLE_ANIM_CTRL -- requirements
Module: circle_anim_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clocks per digit scan slot (legal >=2).
REQ-003 SHALL have parameter STEP_DIV, default 25000000, clocks per animation step (legal >=2).
REQ-004 SHALL have port clk  input  1  single system clock; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port run  input  1  1 = animation advances, 0 = animation frozen; display scanning continues.
REQ-007 SHALL have port dir  input  1  traversal direction, 0 = forward, 1 = reverse (see Configuration).
REQ-008 SHALL have port digit_sel_n  output  NUM_DIGITS  one-hot active-low digit enable for the scanned digit.
REQ-009 SHALL have port row  output  1  to segment pattern driver, 1 = upper circle, 0 = lower circle.
REQ-010 SHALL have port en  output  1  to segment pattern driver, 1 = show circle on the scanned digit, 0 = blank.

Function
REQ-011 SHALL keep scan counter scan_cnt 0..SCAN_DIV-1 and assert an internal scan tick in the cycle where scan_cnt = SCAN_DIV-1, then wrap scan_cnt to 0.
REQ-012 SHALL advance scan index scan_idx 0..NUM_DIGITS-1 by 1 on each scan tick and wrap from NUM_DIGITS-1 to 0.
REQ-013 SHALL keep step counter step_cnt 0..STEP_DIV-1; it increments only while run=1, holds its value while run=0, and asserts a step tick at STEP_DIV-1.
REQ-014 SHALL keep position pos 0..2*NUM_DIGITS-1 (width clog2(2*NUM_DIGITS)) as a snake: pos<NUM_DIGITS -> digit pos, upper row; otherwise -> digit 2*NUM_DIGITS-1-pos, lower row.
REQ-015 SHALL, on a step tick with effective direction forward, set pos to pos+1 and wrap from 2*NUM_DIGITS-1 to 0.
REQ-016 SHALL, on a step tick with effective direction reverse, set pos to pos-1 and wrap from 0 to 2*NUM_DIGITS-1.
REQ-017 SHALL register all outputs: one cycle after state (scan_idx, pos) changes, digit_sel_n has only bit scan_idx low, en = (scan_idx == digit(pos)), and row = row(pos).
REQ-018 SHALL apply simultaneous scan and step ticks in the same cycle; outputs in the next cycle reflect both updated values.
REQ-019 SHALL sample dir only on a step tick; a dir change between ticks has no effect until the next tick.
REQ-020 SHALL never drive more than one digit_sel_n bit low in any cycle.

Reset
REQ-021 SHALL, while rst=1, force scan_cnt=0, step_cnt=0, scan_idx=0, pos=0, digit_sel_n all ones, row=0, en=0.
REQ-022 SHALL, on the first clk edge after rst deasserts, drive digit_sel_n bit0 low, row=1, en=1.
REQ-023 SHALL, on rst asserted mid-operation (mid-scan or mid-step), abandon all counts immediately with no completion of the pending tick.

Configuration
REQ-024 SHALL, with CIRCLE_ANIM_DIR_EN defined, use dir per REQ-015/016.
REQ-025 SHALL, without CIRCLE_ANIM_DIR_EN, keep the dir port, ignore it, and always traverse forward.

Structure
REQ-026 SHALL take the shared constants (segment codes for upper circle, lower circle and off, plus the default divider values) from package circle_seg_pkg, which is also used by the segment pattern driver.
REQ-027 SHALL implement both dividers as two instances of sub-module tick_div (parameter DIV, inputs clk, rst, cnt_en, output tick).

Verification (NUM_DIGITS=4, SCAN_DIV=4, STEP_DIV=32)
REQ-028 SHALL cover reset release: the first edge after release gives digit_sel_n=4'b1110, row=1, en=1, and digit_sel_n changes every 4 clocks in the order 1101, 1011, 0111, 1110.
REQ-029 SHALL cover full forward traversal with run=1: pos steps every 32 clocks; after 4 steps en pulses on digit 3 with row=0; after 8 steps pos=0 again on digit 0 with row=1.
REQ-030 SHALL cover freeze: run=0 for 100 clocks mid-step holds pos and step_cnt while scanning continues; run=1 resumes with the remaining step count.
REQ-031 SHALL cover reverse wrap with CIRCLE_ANIM_DIR_EN defined: dir=1 from pos=0 gives pos=7 on the next tick (digit 0, row=0); without the macro, dir=1 gives pos=1.
REQ-032 SHALL cover reset asserted mid-step at step_cnt=17: all outputs and counters return to reset values asynchronously, without waiting for a clk edge.
REQ-033 SHALL cover a simultaneous scan and step tick in one cycle: the next-cycle en matches a reference model computed from the updated scan_idx and pos.

Source files
------------

// File: rtl/circle_seg_pkg.sv
// Shared constants for the circle animation: segment codes (abcdefg, active-high)
// and default timing; also used by the downstream segment pattern driver.
package circle_seg_pkg;

   localparam logic [6:0] SEG_UPPER_CIRCLE = 7'b1100011;  // a, b, f, g
   localparam logic [6:0] SEG_LOWER_CIRCLE = 7'b0011101;  // c, d, e, g
   localparam logic [6:0] SEG_OFF          = 7'b0000000;

   localparam int unsigned DEF_NUM_DIGITS = 4;
   localparam int unsigned DEF_SCAN_DIV   = 50000;
   localparam int unsigned DEF_STEP_DIV   = 25000000;

   function automatic logic [6:0] circle_code(input logic show, input logic upper);
      if (!show)
         return SEG_OFF;
      return upper ? SEG_UPPER_CIRCLE : SEG_LOWER_CIRCLE;
   endfunction

endpackage

// File: rtl/circle_anim_ctrl_tick_div.sv
// Enable-gated modulo-DIV counter; tick is high for the enabled cycle at DIV-1.
module tick_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cnt_en,
   output logic tick
);

   localparam int unsigned CW = $clog2(DIV);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          at_end;

   assign at_end = (cnt_reg == CW'(DIV - 1));
   // A held counter parked at DIV-1 must not keep ticking.
   assign tick   = cnt_en & at_end;

   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_en)
         cnt_next = at_end ? '0 : cnt_reg + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

endmodule

// File: rtl/circle_anim_ctrl.sv
// Snake-circle animation across a multiplexed digit display with registered outputs.
// Define CIRCLE_ANIM_DIR_EN to honour the dir input; otherwise traversal is always forward.
module circle_anim_ctrl
   import circle_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV,
   parameter int unsigned STEP_DIV   = DEF_STEP_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  dir,
   output logic [NUM_DIGITS-1:0] digit_sel_n,
   output logic                  row,
   output logic                  en
);

   localparam int unsigned SW = $clog2(NUM_DIGITS);
   localparam int unsigned PW = $clog2(2 * NUM_DIGITS);
   localparam logic [SW-1:0] IDX_LAST = SW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(2 * NUM_DIGITS - 1);

   logic                  scan_tick;
   logic                  step_tick;
   logic                  dir_eff;
   logic [SW-1:0]         scan_idx_reg, scan_idx_next;
   logic [PW-1:0]         pos_reg, pos_next;
   logic                  upper;
   logic [PW-1:0]         digit;
   logic [NUM_DIGITS-1:0] sel_n_next;
   logic [NUM_DIGITS-1:0] sel_n_reg;
   logic                  row_reg;
   logic                  en_reg;

   tick_div #(.DIV(SCAN_DIV)) u_scan_div (
      .clk    (clk),
      .rst    (rst),
      .cnt_en (1'b1),
      .tick   (scan_tick)
   );

   tick_div #(.DIV(STEP_DIV)) u_step_div (
      .clk    (clk),
      .rst    (rst),
      .cnt_en (run),
      .tick   (step_tick)
   );

`ifdef CIRCLE_ANIM_DIR_EN
   assign dir_eff = dir;
`else
   // Port kept for pin compatibility; masked so the build stays forward-only.
   assign dir_eff = dir & 1'b0;
`endif

   always_comb begin
      scan_idx_next = scan_idx_reg;
      pos_next      = pos_reg;
      if (scan_tick)
         scan_idx_next = (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + SW'(1);
      if (step_tick) begin
         if (dir_eff)
            pos_next = (pos_reg == '0) ? POS_LAST : pos_reg - PW'(1);
         else
            pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx_reg <= '0;
         pos_reg      <= '0;
      end else begin
         scan_idx_reg <= scan_idx_next;
         pos_reg      <= pos_next;
      end
   end

   // Upper row runs left-to-right over digits, lower row returns right-to-left.
   assign upper = (pos_reg < PW'(NUM_DIGITS));
   assign digit = upper ? pos_reg : (POS_LAST - pos_reg);

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign sel_n_next[gi] = (scan_idx_reg != SW'(gi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_n_reg <= '1;
         row_reg   <= 1'b0;
         en_reg    <= 1'b0;
      end else begin
         sel_n_reg <= sel_n_next;
         row_reg   <= upper;
         en_reg    <= (PW'(scan_idx_reg) == digit);
      end
   end

   assign digit_sel_n = sel_n_reg;
   assign row         = row_reg;
   assign en          = en_reg;

endmodule

// File: tb/tb_circle_anim_ctrl.sv
// Scoreboard bench for circle_anim_ctrl (NUM_DIGITS=4, SCAN_DIV=4, STEP_DIV=32);
// expectations keyed by clock-edge count since reset release.
module tb_circle_anim_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b1;
   logic       dir = 1'b0;
   logic [3:0] digit_sel_n;
   logic       row;
   logic       en;

   circle_anim_ctrl #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .STEP_DIV   (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .dir         (dir),
      .digit_sel_n (digit_sel_n),
      .row         (row),
      .en          (en)
   );

   always #5 clk = ~clk;

   // Edge index since reset release: value k means outputs after edge Ek.
   int k;
   always @(posedge clk or posedge rst) begin
      if (rst)
         k <= 0;
      else
         k <= k + 1;
   end

   typedef struct {
      int         k;
      logic [5:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got sel=%b row=%b en=%b, required sel=%b row=%b en=%b",
                  name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic expect_at(input int kk, input logic [3:0] s, input logic r,
                            input logic e, input string n);
      exp_t item;
      item.k    = kk;
      item.exp  = {s, r, e};
      item.name = n;
      q.push_back(item);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d expectations pending, required 0", tag, q.size());
         q.delete();
      end
   endtask

   task automatic enter_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: one-hot check every cycle plus scoreboard pops at their edge.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(~digit_sel_n) > 1) begin
            errors++;
            $display("FAIL onehot: got sel=%b at k=%0d, required at most one low bit",
                     digit_sel_n, k);
         end
         while (q.size() > 0 && q[0].k <= k) begin
            exp_t e;
            e = q.pop_front();
            if (e.k == k) begin
               check(e.name, {digit_sel_n, row, en}, e.exp);
            end else begin
               checks++;
               errors++;
               $display("FAIL %s_missed: at k=%0d, required check at k=%0d", e.name, k, e.k);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1);
   end

   initial begin
      // ---- reset values and forward traversal ----
      run = 1'b1;
      dir = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_vals", {digit_sel_n, row, en}, 6'b1111_0_0);
      expect_at(1,   4'b1110, 1'b1, 1'b1, "release_d0");
      expect_at(4,   4'b1110, 1'b1, 1'b1, "slot0_end");
      expect_at(5,   4'b1101, 1'b1, 1'b0, "scan_d1");
      expect_at(9,   4'b1011, 1'b1, 1'b0, "scan_d2");
      expect_at(13,  4'b0111, 1'b1, 1'b0, "scan_d3");
      expect_at(17,  4'b1110, 1'b1, 1'b1, "scan_wrap");
      expect_at(32,  4'b0111, 1'b1, 1'b0, "pre_tick");
      expect_at(33,  4'b1110, 1'b1, 1'b0, "sim_tick_pos1");
      expect_at(37,  4'b1101, 1'b1, 1'b1, "pos1_d1");
      expect_at(65,  4'b1110, 1'b1, 1'b0, "pos2_d0");
      expect_at(137, 4'b1011, 1'b0, 1'b0, "pos4_d2");
      expect_at(141, 4'b0111, 1'b0, 1'b1, "pos4_d3");
      expect_at(225, 4'b1110, 1'b0, 1'b1, "pos7_d0");
      expect_at(257, 4'b1110, 1'b1, 1'b1, "pos0_wrap");
      rst = 1'b0;
      drain("forward");

      // ---- freeze: run low for 100 clocks mid-step ----
      enter_reset();
      expect_at(21,  4'b1101, 1'b1, 1'b0, "frz_start");
      expect_at(33,  4'b1110, 1'b1, 1'b1, "frz_hold_pos");
      expect_at(61,  4'b0111, 1'b1, 1'b0, "frz_scan");
      expect_at(121, 4'b1011, 1'b1, 1'b0, "frz_resume");
      expect_at(132, 4'b1110, 1'b1, 1'b1, "frz_before_tick");
      expect_at(133, 4'b1101, 1'b1, 1'b1, "frz_resume_tick");
      rst = 1'b0;
      while (k < 20) @(negedge clk);
      run = 1'b0;
      while (k < 120) @(negedge clk);
      run = 1'b1;
      drain("freeze");

      // ---- reverse from pos 0, then back to forward between ticks ----
      enter_reset();
      dir = 1'b1;
      expect_at(32, 4'b0111, 1'b1, 1'b0, "dir_pre_tick");
`ifdef CIRCLE_ANIM_DIR_EN
      expect_at(33, 4'b1110, 1'b0, 1'b1, "dir_rev_wrap");
      expect_at(45, 4'b0111, 1'b0, 1'b0, "dir_rev_row");
      expect_at(65, 4'b1110, 1'b1, 1'b1, "dir_fwd_again");
`else
      expect_at(33, 4'b1110, 1'b1, 1'b0, "dir_ignored");
      expect_at(45, 4'b0111, 1'b1, 1'b0, "dir_ignored_row");
      expect_at(65, 4'b1110, 1'b1, 1'b0, "dir_fwd_pos2");
`endif
      rst = 1'b0;
      while (k < 40) @(negedge clk);
      dir = 1'b0;
      drain("dir");

      // ---- asynchronous reset at step_cnt=17 ----
      enter_reset();
      expect_at(17, 4'b1110, 1'b1, 1'b1, "pre_abort");
      rst = 1'b0;
      while (k < 17) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_rst", {digit_sel_n, row, en}, 6'b1111_0_0);
      repeat (2) @(negedge clk);
      expect_at(1,  4'b1110, 1'b1, 1'b1, "abort_release");
      expect_at(5,  4'b1101, 1'b1, 1'b0, "abort_scan_restart");
      expect_at(17, 4'b1110, 1'b1, 1'b1, "abort_no_step");
      expect_at(33, 4'b1110, 1'b1, 1'b0, "abort_first_step");
      rst = 1'b0;
      drain("abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
